// File: rtl/level_easy_seq.sv
// level_easy_seq: easy-level target generator and key checker; `LEVEL_REVEAL_EN` enables the reveal_sym hint.
// Latency: progress/guesses/levelDone/active update on the edge after key_valid; loading takes SEQ_LEN cycles.
// Backpressure: none; keys are taken every cycle in PLAY and silently dropped in all other states.
module level_easy_seq #(
  parameter int          SEQ_LEN     = 4,
  parameter int          SYM_W       = 3,
  parameter int          MAX_GUESSES = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             levelStart,
  input  logic             key_valid,
  input  logic [SYM_W-1:0] key_sym,
  output logic             levelDone,
  output logic [2:0]       guesses,
  output logic [3:0]       progress,
  output logic             active,
  output logic [SYM_W-1:0] reveal_sym
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE, S_FAIL} state_t;

  localparam logic [3:0] LAST_IDX = 4'(SEQ_LEN - 1);
  localparam logic [3:0] SEQ_END  = 4'(SEQ_LEN);
  localparam logic [3:0] MAXG     = 4'(MAX_GUESSES);

  state_t                     state_q, state_d;
  logic [7:0]                 lfsr_q, lfsr_d;
  logic [3:0]                 idx_q, idx_d;
  logic [3:0]                 prog_q, prog_d;
  logic [2:0]                 guess_q, guess_d;
  logic [SEQ_LEN*SYM_W-1:0]   target_q, target_d;

  logic [7:0]       lfsr_shift;
  logic [SYM_W-1:0] cur_sym;

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  assign lfsr_shift = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cur_sym    = target_q[prog_q*SYM_W +: SYM_W];

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      idx_q    <= '0;
      prog_q   <= '0;
      guess_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      prog_q   <= prog_d;
      guess_q  <= guess_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    idx_d    = idx_q;
    prog_d   = prog_q;
    guess_d  = guess_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        idx_d   = '0;
        prog_d  = '0;
        guess_d = '0;
        if (levelStart) state_d = S_LOAD;
      end
      S_LOAD: begin
        lfsr_d = lfsr_shift;
        target_d[idx_q*SYM_W +: SYM_W] = lfsr_shift[SYM_W-1:0];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_PLAY;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_PLAY: begin
        if (key_valid) begin
          if (key_sym == cur_sym) begin
            prog_d = prog_q + 4'd1;
            if (prog_d == SEQ_END) state_d = S_DONE;
          end else begin
            if (guess_q != 3'd7) guess_d = guess_q + 3'd1;
            if ({1'b0, guess_d} == MAXG) state_d = S_FAIL;
          end
        end
      end
      default: ;
    endcase
    // Dropping the enable wins over any key or load activity this cycle
    if (state_q != S_IDLE && !levelStart) begin
      state_d  = S_IDLE;
      lfsr_d   = lfsr_q;
      target_d = target_q;
      idx_d    = '0;
      prog_d   = '0;
      guess_d  = '0;
    end
  end

  assign levelDone = (state_q == S_DONE);
  assign active    = (state_q == S_PLAY);
  assign guesses   = guess_q;
  assign progress  = prog_q;

`ifdef LEVEL_REVEAL_EN
  assign reveal_sym = (state_q == S_PLAY) ? cur_sym : '0;
`else
  assign reveal_sym = '0;
`endif

endmodule

// File: doc/level_easy_seq.md
Name: level_easy_seq

Overview:
Game logic for the easy level of the guessing game: produces `levelDone` and `guesses`, which the top-level control FSM consumes, and is enabled by that FSM's `levelEasyStart` level.
- On start, generates a pseudo-random target sequence of symbols.
- Accepts player key strobes and checks each key against the next target symbol.
- Counts correct entries (progress) and wrong entries (guesses).
- Sits directly upstream of the control FSM, between the keyboard decoder and that FSM.

Parameters:
SEQ_LEN, 4, number of symbols in the target sequence (2..8)
SYM_W, 3, symbol width in bits; symbols are 0..2^SYM_W-1
MAX_GUESSES, 3, wrong entries that end the level in FAIL
LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be nonzero

Ports:
Clk  in  1  system clock
reset  in  1  synchronous, active-high reset
levelStart  in  1  level-high enable from the control FSM; low means abort/idle
key_valid  in  1  one-cycle strobe: a key symbol is presented
key_sym  in  SYM_W  symbol of the pressed key; valid with key_valid
levelDone  out  1  high while in DONE
guesses  out  3  count of wrong entries, saturating at 7
progress  out  4  number of symbols matched so far (0..SEQ_LEN)
active  out  1  high while in PLAY
reveal_sym  out  SYM_W  target symbol at the current index (see Optional Feature)

Behaviour:
- Clock and reset: one clock `Clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, `levelDone`=0, `guesses`=0, `progress`=0, `active`=0, `reveal_sym`=0, LFSR=`LFSR_SEED`, index=0, all target registers=0.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left with the feedback bit into bit 0.
  - Advances only in LOAD, so consecutive levels get different sequences.
  - Symbol = LFSR[SYM_W-1:0] after the shift.
- States:
  - IDLE: all counters held at 0. `levelStart`=1 -> LOAD (index cleared).
  - LOAD: one symbol per cycle into target[index]; index++. After SEQ_LEN cycles -> PLAY with index=0, `active`=1. `key_valid` is ignored.
  - PLAY: on `key_valid`, compare `key_sym` with target[`progress`]:
    - Match: `progress`++. If the new `progress`==SEQ_LEN -> DONE.
    - Mismatch: `guesses`++ (saturating at 7); `progress` unchanged. If the new `guesses`==MAX_GUESSES -> FAIL.
  - DONE: `levelDone`=1, `active`=0; keys ignored. Holds until `levelStart`=0.
  - FAIL: `levelDone`=0, `active`=0; `guesses` held at its value so the control FSM sees it exceed 2. Keys ignored. Holds until `levelStart`=0.
- Latency: outputs are registered. `progress`, `guesses`, `levelDone` and `active` update on the edge after the `key_valid` cycle. Keys are accepted in back-to-back cycles.
- Abort: `levelStart`=0 in any non-IDLE state -> IDLE on the next edge. `guesses`, `progress` and `levelDone` clear on that edge; the LFSR is not reset.
- Simultaneous events (priority): `reset` > `levelStart`=0 > key handling.
- `key_valid` while in IDLE, LOAD, DONE or FAIL has no effect.
- Index and `progress` never wrap past SEQ_LEN.

Optional Feature:
- Macro: `LEVEL_REVEAL_EN`.
- Defined: `reveal_sym` = target[`progress`] while in PLAY, 0 otherwise. Used for the on-screen hint and for bench self-checking.
- Undefined: `reveal_sym` tied to 0; no extra logic.

Test Plan:
1. `reset`=1 for 2 cycles -> all outputs 0, state IDLE; `key_valid` pulses produce no change.
2. `levelStart`=1 (`LEVEL_REVEAL_EN` defined) -> `active`=1 after exactly SEQ_LEN+1 cycles, `progress`=0. Each key then drives `key_sym`=`reveal_sym` -> after 4 keys `progress`=4 and `levelDone`=1 on the edge after the 4th key, `guesses`=0.
3. In PLAY, 3 keys with `key_sym`=`reveal_sym`^1 -> `guesses`=1, 2, 3; FAIL after the 3rd; `active`=0, `levelDone`=0, `guesses` held at 3. A 4th key leaves it at 3.
4. Mixed back-to-back sequence (correct, wrong, correct) -> `progress`=2, `guesses`=1, one update per cycle.
5. `levelStart` dropped mid-PLAY with `progress`=2, `guesses`=1 -> next edge: IDLE, all counters 0. Restart gives a target sequence differing from the first.
6. Same-cycle `reset`=1 and matching `key_valid` in PLAY -> IDLE with `progress`=0; the key is discarded.
